dmem_bus_arbiter: RTL and testbench

//  Shares the single data-memory/MMIO bus between the CPU MEM stage (master 0) and a secondary

---
 rtl/dmem_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_bus_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_arbiter.sv
// Round-robin arbiter sharing the data-memory/MMIO bus between the CPU MEM stage (m0) and a
// secondary master (m1); one outstanding transaction, bus timeout reported as an error.
module dmem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [2:0]    m0_dmtype,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  output logic          m0_stall,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [2:0]    m1_dmtype,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic [2:0]    bus_dmtype,
  input  logic          bus_ready,
  input  logic [DW-1:0] bus_rdata,
  output logic          busy,
  output logic          grant_id
);

  // state | meaning
  // IDLE  | waiting for a request; arbitration happens here
  // BUSY  | bus_req high, payload held, waiting for bus_ready or timeout
  // RESP  | one-cycle ack with rdata/err to the winning master
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit            TO_EN    = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_last_grant;
  logic          r_grant_id;
  logic          r_bus_we;
  logic [AW-1:0] r_bus_addr;
  logic [DW-1:0] r_bus_wdata;
  logic [2:0]    r_bus_dmtype;
  logic          r_ack0;
  logic          r_ack1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic          r_err0;
  logic          r_err1;

  logic          w_m1_wins;
  logic          w_timeout;
  logic [DW-1:0] w_resp_data;

  // On a tie the master that did not win last time gets the bus.
  assign w_m1_wins   = m1_req & (~m0_req | ~r_last_grant);
  assign w_timeout   = TO_EN && (r_cnt == CNT_LAST);
  assign w_resp_data = bus_ready ? bus_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_bus_dmtype <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
    end else begin
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (m0_req | m1_req) begin
            r_state      <= S_BUSY;
            r_cnt        <= '0;
            r_grant_id   <= w_m1_wins;
            r_last_grant <= w_m1_wins;
            r_bus_we     <= w_m1_wins ? m1_we     : m0_we;
            r_bus_addr   <= w_m1_wins ? m1_addr   : m0_addr;
            r_bus_wdata  <= w_m1_wins ? m1_wdata  : m0_wdata;
            r_bus_dmtype <= w_m1_wins ? m1_dmtype : m0_dmtype;
          end
        end
        S_BUSY: begin
          // bus_ready takes priority over a coincident timeout
          if (bus_ready | w_timeout) begin
            r_state <= S_RESP;
            r_cnt   <= '0;
            if (r_grant_id) begin
              r_ack1   <= 1'b1;
              r_rdata1 <= w_resp_data;
              r_err1   <= ~bus_ready;
            end else begin
              r_ack0   <= 1'b1;
              r_rdata0 <= w_resp_data;
              r_err0   <= ~bus_ready;
            end
          end else if (TO_EN) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus_req    = (r_state == S_BUSY);
  assign busy       = (r_state != S_IDLE);
  assign grant_id   = r_grant_id;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;
  assign bus_dmtype = r_bus_dmtype;
  assign m0_ack     = r_ack0;
  assign m0_rdata   = r_rdata0;
  assign m0_err     = r_err0;
  assign m0_stall   = m0_req & ~r_ack0;
  assign m1_ack     = r_ack1;
  assign m1_rdata   = r_rdata1;
  assign m1_err     = r_err1;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Bench for dmem_bus_arbiter: transaction-level reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with occasional async resets.
module tb_dmem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rq[2];
  logic          we_v[2];
  logic [AW-1:0] ad[2];
  logic [DW-1:0] wd[2];
  logic [2:0]    dt[2];
  logic          m0_ack, m0_err, m0_stall, m1_ack, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          bus_req, bus_we, bus_ready, busy, grant_id;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;
  logic [2:0]    bus_dmtype;

  always #5 clk = ~clk;

  dmem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(rq[0]), .m0_we(we_v[0]), .m0_addr(ad[0]), .m0_wdata(wd[0]), .m0_dmtype(dt[0]),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err), .m0_stall(m0_stall),
    .m1_req(rq[1]), .m1_we(we_v[1]), .m1_addr(ad[1]), .m1_wdata(wd[1]), .m1_dmtype(dt[1]),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_dmtype(bus_dmtype), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one in-flight transaction, its owner and how long it has waited.
  bit            md_inflight, md_resp, md_owner, md_last;
  int            md_waited;
  logic          md_we;
  logic [AW-1:0] md_addr;
  logic [DW-1:0] md_wdata;
  logic [2:0]    md_dmt;
  logic          md_ack[2];
  logic [DW-1:0] md_rdata[2];
  logic          md_err[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    md_inflight = 0; md_resp = 0; md_owner = 0; md_last = 1; md_waited = 0;
    md_we = 0; md_addr = '0; md_wdata = '0; md_dmt = '0;
    for (int m = 0; m < 2; m++) begin
      md_ack[m] = 0; md_rdata[m] = '0; md_err[m] = 0;
    end
  endtask

  // Advances the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    bit was_resp;
    was_resp = md_resp;
    md_resp = 0;
    for (int m = 0; m < 2; m++) begin
      md_ack[m] = 0; md_rdata[m] = '0; md_err[m] = 0;
    end
    if (was_resp) begin
      md_inflight = 0;
    end else if (md_inflight) begin
      md_waited++;
      if (bus_ready || (TO != 0 && md_waited == TO)) begin
        md_inflight = 0;
        md_resp = 1;
        md_ack[md_owner] = 1;
        md_rdata[md_owner] = bus_ready ? bus_rdata : '0;
        md_err[md_owner] = !bus_ready;
      end
    end else if (rq[0] || rq[1]) begin
      md_owner = (rq[0] && rq[1]) ? !md_last : rq[1];
      md_last = md_owner;
      md_we = we_v[md_owner]; md_addr = ad[md_owner];
      md_wdata = wd[md_owner]; md_dmt = dt[md_owner];
      md_inflight = 1;
      md_waited = 0;
    end
  endtask

  task automatic check_all();
    chk("bus_req", bus_req, md_inflight);
    chk("busy", busy, md_inflight | md_resp);
    chk("grant_id", grant_id, md_owner);
    chk("bus_we", bus_we, md_we);
    chk("bus_addr", bus_addr, md_addr);
    chk("bus_wdata", bus_wdata, md_wdata);
    chk("bus_dmtype", bus_dmtype, md_dmt);
    chk("m0_ack", m0_ack, md_ack[0]);
    chk("m0_rdata", m0_rdata, md_rdata[0]);
    chk("m0_err", m0_err, md_err[0]);
    chk("m0_stall", m0_stall, rq[0] & !md_ack[0]);
    chk("m1_ack", m1_ack, md_ack[1]);
    chk("m1_rdata", m1_rdata, md_rdata[1]);
    chk("m1_err", m1_err, md_err[1]);
  endtask

  task automatic apply();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // Called at a falling edge; asserts reset mid-cycle and checks outputs clear at once.
  task automatic do_reset();
    #2;
    rst = 0; rq[0] = 0; rq[1] = 0; bus_ready = 0;
    #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_ack", m1_ack, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m0_stall", m0_stall, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    check_all();
  endtask

  task automatic new_payload(input int m);
    rq[m] = 1; we_v[m] = 1'($urandom_range(0, 1));
    ad[m] = $urandom; wd[m] = $urandom; dt[m] = 3'($urandom_range(0, 7));
  endtask

  initial begin
    int order[$];
    int n;
    rst = 0; bus_ready = 0; bus_rdata = '0;
    for (int m = 0; m < 2; m++) begin
      rq[m] = 0; we_v[m] = 0; ad[m] = '0; wd[m] = '0; dt[m] = '0;
    end
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: m0 load, bus_ready two cycles after bus_req rises
    rq[0] = 1; we_v[0] = 0; ad[0] = 32'h10; dt[0] = 3'b010;
    apply();
    chk("t1_bus_req", bus_req, 1);
    chk("t1_bus_addr", bus_addr, 32'h10);
    chk("t1_stall", m0_stall, 1);
    apply();
    chk("t1_stall2", m0_stall, 1);
    bus_ready = 1; bus_rdata = 32'hDEADBEEF;
    apply();
    chk("t1_ack", m0_ack, 1);
    chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
    chk("t1_err", m0_err, 0);
    chk("t1_stall_ack", m0_stall, 0);
    rq[0] = 0; bus_ready = 0;
    apply();
    chk("t1_ack_gone", m0_ack, 0);
    chk("t1_rdata_gone", m0_rdata, 0);

    // 2: simultaneous requests after reset alternate m0, m1, m0
    do_reset();
    new_payload(0); new_payload(1);
    bus_ready = 1;
    for (int i = 0; i < 20 && order.size() < 3; i++) begin
      apply();
      if (m0_ack) order.push_back(0);
      else if (m1_ack) order.push_back(1);
    end
    while (order.size() < 3) order.push_back(-1);
    chk("t2_first", order[0], 0);
    chk("t2_second", order[1], 1);
    chk("t2_third", order[2], 0);
    rq[0] = 0; rq[1] = 0; bus_ready = 0;
    apply();

    // 3: m1 store held on the bus while m0 waits
    rq[1] = 1; we_v[1] = 1; ad[1] = 32'h20; wd[1] = 32'h12345678; dt[1] = 3'd0;
    apply();
    for (int i = 0; i < 3; i++) begin
      chk("t3_bus_we", bus_we, 1);
      chk("t3_bus_addr", bus_addr, 32'h20);
      chk("t3_bus_wdata", bus_wdata, 32'h12345678);
      chk("t3_grant", grant_id, 1);
      if (i == 0) begin
        rq[0] = 1; we_v[0] = 0; ad[0] = 32'h44; dt[0] = 3'b010;
      end
      if (i == 2) begin
        bus_ready = 1; bus_rdata = 32'h0BADF00D;
      end
      apply();
      chk("t3_m0_stall", m0_stall, 1);
    end
    chk("t3_m1_ack", m1_ack, 1);
    chk("t3_m0_noack", m0_ack, 0);
    rq[1] = 0; bus_ready = 0;
    apply();
    apply();
    chk("t3_m0_granted", grant_id, 0);
    chk("t3_m0_addr", bus_addr, 32'h44);
    bus_ready = 1; bus_rdata = 32'h55;
    apply();
    chk("t3_m0_ack", m0_ack, 1);
    rq[0] = 0; bus_ready = 0;
    apply();

    // 4: timeout after TO busy cycles, then ready exactly on the timeout cycle
    rq[0] = 1; we_v[0] = 0; ad[0] = 32'h80; bus_rdata = 32'hFFFF0000;
    apply();
    n = 0;
    for (int i = 0; i < 10 && !m0_ack; i++) begin
      apply();
      n++;
    end
    chk("t4_to_cycles", n, TO);
    chk("t4_to_err", m0_err, 1);
    chk("t4_to_rdata", m0_rdata, 0);
    rq[0] = 0;
    apply();
    rq[0] = 1;
    for (int i = 0; i < TO; i++) apply();
    chk("t4_last_busy", bus_req, 1);
    bus_ready = 1; bus_rdata = 32'hCAFE0004;
    apply();
    chk("t4_ready_ack", m0_ack, 1);
    chk("t4_ready_err", m0_err, 0);
    chk("t4_ready_rdata", m0_rdata, 32'hCAFE0004);
    rq[0] = 0; bus_ready = 0;
    apply();

    // 5: reset during BUSY, no stale ack afterwards, next m0 request served
    rq[0] = 1; ad[0] = 32'h90;
    apply();
    apply();
    do_reset();
    apply();
    chk("t5_no_stale", m0_ack | m1_ack, 0);
    rq[0] = 1; ad[0] = 32'h94; bus_ready = 1; bus_rdata = 32'h77;
    n = 0;
    for (int i = 0; i < 10 && !m0_ack; i++) begin
      apply();
      n++;
    end
    chk("t5_served_cycles", n, 2);
    chk("t5_rdata", m0_rdata, 32'h77);
    rq[0] = 0; bus_ready = 0;
    apply();

    // Randomized traffic
    for (int it = 0; it < 4000; it++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        continue;
      end
      for (int m = 0; m < 2; m++) begin
        if (rq[m] && md_ack[m]) begin
          if ($urandom_range(0, 1) == 1) new_payload(m);
          else rq[m] = 0;
        end else if (!rq[m]) begin
          if ($urandom_range(0, 2) == 0) new_payload(m);
        end else if (md_inflight && md_owner == m[0] && $urandom_range(0, 15) == 0) begin
          rq[m] = 0;
        end
      end
      bus_ready = ($urandom_range(0, 3) == 0);
      bus_rdata = $urandom;
      apply();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
